// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-master (instruction cache / data cache) burst arbiter in
//               front of a single memory port. Each grant covers one burst of
//               BEATS words. Every burst end and every abandon returns to IDLE,
//               so one idle bubble always separates two grants.
//               Optional macro ROUND_ROBIN_EN: simultaneous requests alternate
//               with the previous owner. Without it, the data side always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int BEATS = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          HRequestI,
    input  logic [AW-1:0] HAddrI,
    input  logic          HRequestM,
    input  logic          HWriteM,
    input  logic [AW-1:0] HAddrM,
    input  logic [DW-1:0] HWDataM,
    input  logic          HReadyMem,
    input  logic [DW-1:0] HRDataMem,
    output logic          HRequest,
    output logic          HWrite,
    output logic [AW-1:0] HAddr,
    output logic [DW-1:0] HWData,
    output logic [DW-1:0] HRData,
    output logic          BusReadyI,
    output logic          BusReadyM,
    output logic          GrantM
);

    localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_M = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q,  beat_d;
    logic          last_m_q, last_m_d;

    logic          pick_m;
    logic          owner_req;
    logic          owner_is_m;

    // Decide which side wins when arbitrating out of IDLE
    always_comb begin
`ifdef ROUND_ROBIN_EN
        // On a tie, the side that did not finish the last burst wins
        pick_m = HRequestM & (~HRequestI | ~last_m_q);
`else
        // Data side has fixed priority; last_m_q is tracked but not consulted
        pick_m = HRequestM;
`endif
    end

    // Request line of whichever side currently owns the bus
    always_comb begin
        owner_is_m = (state_q == GRANT_M);
        owner_req  = 1'b0;
        if (state_q == GRANT_M) begin
            owner_req = HRequestM;
        end else if (state_q == GRANT_I) begin
            owner_req = HRequestI;
        end
    end

    // Next-state, beat counter and last-owner computation
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_m_d = last_m_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (pick_m) begin
                    state_d = GRANT_M;
                end else if (HRequestI) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I, GRANT_M: begin
                if (!owner_req) begin
                    // Owner walked away: drop the burst, keep fairness history
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (HReadyMem) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        beat_d   = '0;
                        last_m_d = owner_is_m;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                // HReadyMem low: memory wait state, everything holds
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Bus-facing outputs, all derived from the registered owner
    always_comb begin
        GrantM    = (state_q == GRANT_M);
        HRequest  = owner_req;
        HAddr     = '0;
        if (state_q == GRANT_M) begin
            HAddr = HAddrM;
        end else if (state_q == GRANT_I) begin
            HAddr = HAddrI;
        end
        HWrite    = (state_q == GRANT_M) & HWriteM;
        HWData    = HWDataM;
        HRData    = HRDataMem;
        BusReadyI = (state_q == GRANT_I) & HRequestI & HReadyMem;
        BusReadyM = (state_q == GRANT_M) & HRequestM & HReadyMem;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_m_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_m_q <= last_m_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Directed scenarios
//               followed by random traffic, all compared every cycle against a
//               burst-level reference model. Honours ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int BEATS = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          HRequestI, HRequestM, HWriteM, HReadyMem;
    logic [AW-1:0] HAddrI, HAddrM;
    logic [DW-1:0] HWDataM, HRDataMem;
    logic          HRequest, HWrite, BusReadyI, BusReadyM, GrantM;
    logic [AW-1:0] HAddr;
    logic [DW-1:0] HWData, HRData;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus (0 none, 1 instr, 2 data),
    // how many words of the current burst have been delivered,
    // and which side completed the most recent full burst.
    int owner       = 0;
    int words_done  = 0;
    bit last_was_m  = 1'b0;

    // Observed strobe tallies for scenario-level checks
    int seen_i = 0;
    int seen_m = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.BEATS(BEATS), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .HRequestI (HRequestI),
        .HAddrI    (HAddrI),
        .HRequestM (HRequestM),
        .HWriteM   (HWriteM),
        .HAddrM    (HAddrM),
        .HWDataM   (HWDataM),
        .HReadyMem (HReadyMem),
        .HRDataMem (HRDataMem),
        .HRequest  (HRequest),
        .HWrite    (HWrite),
        .HAddr     (HAddr),
        .HWData    (HWData),
        .HRData    (HRData),
        .BusReadyI (BusReadyI),
        .BusReadyM (BusReadyM),
        .GrantM    (GrantM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against what the model says the bus should look like
    task automatic check_outputs();
        bit            has_i, has_m;
        logic [AW-1:0] exp_addr;
        logic          exp_req;
        has_i    = (owner == 1);
        has_m    = (owner == 2);
        exp_req  = has_i ? HRequestI : (has_m ? HRequestM : 1'b0);
        exp_addr = has_i ? HAddrI : (has_m ? HAddrM : '0);
        chk("GrantM",    GrantM,    has_m);
        chk("HRequest",  HRequest,  exp_req);
        chk("HAddr",     HAddr,     exp_addr);
        chk("HWrite",    HWrite,    has_m && HWriteM);
        chk("HWData",    HWData,    HWDataM);
        chk("HRData",    HRData,    HRDataMem);
        chk("BusReadyI", BusReadyI, has_i && HRequestI && HReadyMem);
        chk("BusReadyM", BusReadyM, has_m && HRequestM && HReadyMem);
        if (BusReadyI) seen_i++;
        if (BusReadyM) seen_m++;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_advance();
        bit owner_req;
        if (owner == 0) begin
            if (HRequestI && HRequestM) begin
`ifdef ROUND_ROBIN_EN
                owner = last_was_m ? 1 : 2;
`else
                owner = 2;
`endif
            end else if (HRequestM) begin
                owner = 2;
            end else if (HRequestI) begin
                owner = 1;
            end
            words_done = 0;
        end else begin
            owner_req = (owner == 1) ? HRequestI : HRequestM;
            if (!owner_req) begin
                owner      = 0;
                words_done = 0;
            end else if (HReadyMem) begin
                words_done++;
                if (words_done == BEATS) begin
                    last_was_m = (owner == 2);
                    owner      = 0;
                    words_done = 0;
                end
            end
        end
    endtask

    // One clock: inputs were applied just after the previous edge
    task automatic cycle();
        #3;
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        reset     = 1'b1;
        HRequestI = 1'b0; HRequestM = 1'b0; HWriteM = 1'b0; HReadyMem = 1'b1;
        HAddrI    = 32'h0000_0040; HAddrM = 32'h0000_0080;
        HWDataM   = 32'h1234_5678; HRDataMem = 32'hCAFE_F00D;

        // Outputs during reset, pass-through paths excepted
        #2;
        chk("rst_GrantM",   GrantM,    1'b0);
        chk("rst_HRequest", HRequest,  1'b0);
        chk("rst_HAddr",    HAddr,     '0);
        chk("rst_HWData",   HWData,    32'h1234_5678);
        chk("rst_HRData",   HRData,    32'hCAFE_F00D);
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle with no requests
        run(2);

        // Instruction-only burst with memory always ready
        seen_i = 0;
        HRequestI = 1'b1;
        run(6);
        chk("i_burst_strobes", seen_i, 4);
        HRequestI = 1'b0;
        run(1);

        // Both request: fixed priority repeats M, round robin alternates
        seen_i = 0; seen_m = 0;
        HRequestI = 1'b1; HRequestM = 1'b1;
        run(15);
`ifdef ROUND_ROBIN_EN
        chk("tie_strobes_m", seen_m, 8);
        chk("tie_strobes_i", seen_i, 4);
`else
        chk("tie_strobes_m", seen_m, 12);
        chk("tie_strobes_i", seen_i, 0);
`endif
        HRequestI = 1'b0; HRequestM = 1'b0;
        run(2);

        // Writeback burst with memory wait states every other cycle
        seen_m = 0;
        HRequestM = 1'b1; HWriteM = 1'b1; HAddrM = 32'h100; HWDataM = 32'hDEAD_BEEF;
        cycle();
        for (int k = 0; k < 8; k++) begin
            HReadyMem = ~k[0];
            cycle();
        end
        chk("wb_strobes", seen_m, 4);
        HReadyMem = 1'b1; HRequestM = 1'b0; HWriteM = 1'b0;
        run(2);

        // Data side abandons after two beats while instruction side waits
        seen_i = 0;
        HRequestM = 1'b1;
        cycle();
        HRequestI = 1'b1;
        run(2);
        HRequestM = 1'b0;
        run(3);
        chk("abandon_then_i", GrantM, 1'b0);
        run(4);
        chk("abandon_i_strobes", seen_i, 4);
        HRequestI = 1'b0;
        run(2);

        // Asynchronous reset at beat 2 of an instruction burst
        HRequestI = 1'b1;
        run(3);
        #1 reset = 1'b1;
        #1;
        chk("arst_HRequest",  HRequest,  1'b0);
        chk("arst_BusReadyI", BusReadyI, 1'b0);
        chk("arst_HAddr",     HAddr,     '0);
        chk("arst_HRData",    HRData,    HRDataMem);
        owner = 0; words_done = 0; last_was_m = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen_i = 0;
        run(6);
        chk("post_rst_strobes", seen_i, 4);
        HRequestI = 1'b0;
        run(2);

        // Random traffic with sticky requests
        for (int k = 0; k < 400; k++) begin
            HRequestI = HRequestI ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
            if (!HRequestM) HWriteM = $urandom_range(0, 1) == 1;
            HRequestM = HRequestM ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
            HReadyMem = $urandom_range(0, 3) != 0;
            HAddrI    = $urandom;
            HAddrM    = $urandom;
            HWDataM   = $urandom;
            HRDataMem = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: BEATS, 4, words per burst; the burst counter is clog2(BEATS) bits wide.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: DW, 32, data width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 HRequestI  input  1  instruction-cache bus request.
REQ-007 HAddrI  input  AW  instruction-cache word address.
REQ-008 HRequestM  input  1  data-cache bus request.
REQ-009 HWriteM  input  1  data-cache write (writeback) request.
REQ-010 HAddrM  input  AW  data-cache word address.
REQ-011 HWDataM  input  DW  data-cache write data.
REQ-012 HReadyMem  input  1  memory beat complete.
REQ-013 HRDataMem  input  DW  memory read data.
REQ-014 HRequest  output  1  request to memory.
REQ-015 HWrite  output  1  write to memory.
REQ-016 HAddr  output  AW  address to memory.
REQ-017 HWData  output  DW  write data to memory.
REQ-018 HRData  output  DW  read data to both caches.
REQ-019 BusReadyI  output  1  beat-done strobe, instruction side.
REQ-020 BusReadyM  output  1  beat-done strobe, data side.
REQ-021 GrantM  output  1  1 = data side owns the bus.

Function
REQ-022 States: IDLE, GRANT_I, GRANT_M; a 2-bit Beat counter; a 1-bit LastM flag.
REQ-023 IDLE, no requests: stay in IDLE; HRequest=0, HWrite=0.
REQ-024 IDLE, one request: next cycle enter the matching GRANT state.
REQ-025 IDLE, both requests: winner selected per REQ-037/038.
REQ-026 In GRANT_x: HRequest = HRequestx; HAddr = HAddrx.
REQ-027 HWrite = GrantM & HWriteM; HWData = HWDataM at all times.
REQ-028 HRData = HRDataMem combinationally; no latency added.
REQ-029 BusReadyI = (state==GRANT_I) & HRequestI & HReadyMem; BusReadyM is the same with GRANT_M and HRequestM.
REQ-030 A BusReady strobe is never asserted to the non-granted side.
REQ-031 Beat counter: increments on each BusReady of the owner; wraps from BEATS-1 to 0.
REQ-032 Burst end: Beat==BEATS-1 & HReadyMem -> IDLE next cycle, Beat=0, LastM updated to the finished owner.
REQ-033 Every burst end returns to IDLE; one idle bubble always precedes re-arbitration.
REQ-034 Abandon: owner request low while granted -> IDLE next cycle, Beat=0, no strobe that cycle, LastM unchanged.
REQ-035 HReadyMem low: Beat holds and state holds indefinitely (memory wait states).
REQ-036 A data-side writeback burst and the following read burst are separate bursts, each arbitrated separately.

Configuration
REQ-037 Without ROUND_ROBIN_EN: on a simultaneous request in IDLE, data side wins; LastM is kept but unused.
REQ-038 With ROUND_ROBIN_EN defined: on a simultaneous request in IDLE, the side not equal to LastM wins (LastM=1 -> I wins).

Reset
REQ-039 Asynchronous reset at any time, including mid-burst: state=IDLE, Beat=0, LastM=0.
REQ-040 During and after reset, all outputs are 0 until the next arbitration, except HRData and HWData, which pass through.

Verification
REQ-041 HRequestI=1 only, HReadyMem=1 continuously -> GRANT_I at cycle 1, BusReadyI on 4 consecutive cycles, IDLE on cycle 5.
REQ-042 Both requests are raised in IDLE, without ROUND_ROBIN_EN -> GrantM=1 first; after a 4-beat burst + 1 idle cycle, GrantM=1 again while HRequestM is held.
REQ-043 Same stimulus as REQ-042 with ROUND_ROBIN_EN -> bursts alternate M, I, M; exactly 4 strobes per burst.
REQ-044 GRANT_M with HWriteM=1, HAddrM=0x100, HWDataM=0xDEADBEEF, HReadyMem toggling 1,0,1,0... -> HWrite=1, HAddr=0x100, 4 strobes over 8 cycles, Beat holds on 0 cycles.
REQ-045 HRequestM drops after 2 beats -> IDLE next cycle, Beat=0; a pending HRequestI is granted on the following cycle.
REQ-046 Reset asserted at beat 2 of a burst -> outputs 0 immediately (asynchronous); after release, a fresh request starts at Beat=0.
